seq7_stepper: RTL



---
 rtl/seq7_stepper.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq7_stepper.sv
// rtl/seq7_stepper.sv - seven-segment sequence stepper over a writable digit table
// Displays preview the entry the next step tick will commit (Mealy).
module seq7_stepper #(
  parameter int DIV_COUNT = 50000000,
  parameter int SEQ_LEN   = 9,
  parameter int DIGITS    = 2
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [1:0]          MODE,
  input  logic                BOUNCE,
  input  logic                WR_EN,
  input  logic [3:0]          WR_ADDR,
  input  logic [3:0]          WR_DATA,
  output logic [7*DIGITS-1:0] HEX,
  output logic [3:0]          INDEX,
  output logic                TICK
);

  localparam int              DW         = $clog2(DIV_COUNT);
  localparam logic [DW-1:0]   DIV_LAST   = DW'(DIV_COUNT - 1);
  localparam logic [3:0]      IDX_LAST   = 4'(SEQ_LEN - 1);
  localparam logic [3:0]      IDX_PREV   = 4'(SEQ_LEN - 2);
  localparam logic [63:0]     TABLE_INIT = 64'h0000_0007_0145_4382;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_BWD  = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_t;

  logic [DW-1:0] r_div;
  logic [3:0]    r_index;
  dir_t          r_dir;
  logic          r_blank;
  logic [3:0]    r_table [16];

  logic          w_tick;
  logic [3:0]    w_pend;
  logic          w_flip;
  logic          w_dark;
  logic [3:0]    w_index_nxt;
  dir_t          w_dir_nxt;
  logic          w_blank_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_tick = (r_div == DIV_LAST);
  assign w_dark = r_blank | (MODE == MODE_OFF);
  assign TICK   = w_tick;
  assign INDEX  = r_index;

  // Pending index: where the next tick would land, given current mode and direction.
  always_comb begin
    w_pend = r_index;
    w_flip = 1'b0;
    case (MODE)
      MODE_BWD: w_pend = (r_index == 4'd0) ? IDX_LAST : r_index - 4'd1;
      MODE_RUN: begin
        if (!BOUNCE) begin
          w_pend = (r_index == IDX_LAST) ? 4'd0 : r_index + 4'd1;
        end else if (r_dir == DIR_FWD) begin
          if (r_index == IDX_LAST) begin
            w_pend = IDX_PREV;
            w_flip = 1'b1;
          end else begin
            w_pend = r_index + 4'd1;
          end
        end else begin
          if (r_index == 4'd0) begin
            w_pend = 4'd1;
            w_flip = 1'b1;
          end else begin
            w_pend = r_index - 4'd1;
          end
        end
      end
      default: w_pend = r_index;
    endcase
  end

  // A tick while blanked restarts from entry 0 instead of stepping.
  always_comb begin
    w_index_nxt = r_index;
    w_dir_nxt   = r_dir;
    w_blank_nxt = r_blank;
    if (w_tick) begin
      if (MODE == MODE_OFF) begin
        w_blank_nxt = 1'b1;
      end else if (r_blank) begin
        w_index_nxt = 4'd0;
        w_dir_nxt   = DIR_FWD;
        w_blank_nxt = 1'b0;
      end else begin
        w_index_nxt = w_pend;
        if (w_flip) begin
          w_dir_nxt = (r_dir == DIR_FWD) ? DIR_BWD : DIR_FWD;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_div   <= '0;
      r_index <= 4'd0;
      r_dir   <= DIR_FWD;
      r_blank <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_table[i] <= TABLE_INIT[4*i +: 4];
      end
    end else begin
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_index <= w_index_nxt;
      r_dir   <= w_dir_nxt;
      r_blank <= w_blank_nxt;
      if (WR_EN && (WR_ADDR <= IDX_LAST)) begin
        r_table[WR_ADDR] <= WR_DATA;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [4:0] w_sum;
    logic [3:0] w_sel;
    assign w_sum = {1'b0, w_pend} + 5'(k);
    assign w_sel = (w_sum >= 5'(SEQ_LEN)) ? 4'(w_sum - 5'(SEQ_LEN)) : w_sum[3:0];
    assign HEX[7*k +: 7] = w_dark ? 7'h7F : seg_decode(r_table[w_sel]);
  end

  // Unused mode encoding kept named for readability of the case above.
  logic w_unused;
  assign w_unused = (MODE_HOLD == 2'b00);

endmodule
